// File: rtl/apb_arbiter_if.sv
// Signal bundle between two requesting masters, the apb_arbiter and its APB slave.
// Modport master is the arbiter's view; modport slave is the view of the surrounding environment.
interface apb_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STB_WIDTH = DATA_WIDTH / 8;

  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_write;
  logic [STB_WIDTH-1:0]  m0_stb;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m0_ready;
  logic                  m0_err;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_write;
  logic [STB_WIDTH-1:0]  m1_stb;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_ready;
  logic                  m1_err;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [STB_WIDTH-1:0]  pstb;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  perr;

  modport master (
    input  m0_req, m0_addr, m0_wdata, m0_write, m0_stb,
    input  m1_req, m1_addr, m1_wdata, m1_write, m1_stb,
    output m0_rdata, m0_ready, m0_err, m1_rdata, m1_ready, m1_err,
    output paddr, pdata, pstb, pwrite, psel, penable,
    input  prdata, pready, perr
  );

  modport slave (
    output m0_req, m0_addr, m0_wdata, m0_write, m0_stb,
    output m1_req, m1_addr, m1_wdata, m1_write, m1_stb,
    input  m0_rdata, m0_ready, m0_err, m1_rdata, m1_ready, m1_err,
    input  paddr, pdata, pstb, pwrite, psel, penable,
    output prdata, pready, perr
  );
endinterface

// File: rtl/apb_arbiter.sv
// Two-master arbiter and APB sequencer with an ACCESS-phase watchdog.
// Define APB_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module apb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic          pclk,
  input logic          presetn,
  apb_arbiter_if.master bus
);
  localparam int unsigned STB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned WDW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [STB_WIDTH-1:0]  pstb_q, pstb_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [WDW-1:0]        wdog_q, wdog_d;
  logic                  any_req;
  logic                  win;
  logic                  timeout;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef APB_ARB_RR_EN
  logic last_q;

  // On a tie the master not served last wins; resets to 1 so master 0 takes the first tie.
  assign win = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_q <= 1'b1;
    end else if (state_q == StIdle && any_req) begin
      last_q <= win;
    end
  end
`else
  assign win = ~bus.m0_req;
`endif

  assign timeout = (TIMEOUT != 0) && (wdog_q == WDW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    paddr_d  = paddr_q;
    pdata_d  = pdata_q;
    pstb_d   = pstb_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d  = win;
          paddr_d  = win ? bus.m1_addr  : bus.m0_addr;
          pdata_d  = win ? bus.m1_wdata : bus.m0_wdata;
          pstb_d   = win ? bus.m1_stb   : bus.m0_stb;
          pwrite_d = win ? bus.m1_write : bus.m0_write;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        wdog_d  = WDW'(1);
        state_d = StAccess;
      end
      StAccess: begin
        if (bus.pready) begin
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = bus.perr;
          state_d = StResp;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StResp: begin
        wdog_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      pstb_q   <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      paddr_q  <= paddr_d;
      pdata_q  <= pdata_d;
      pstb_q   <= pstb_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // Phase strobes decode straight from state so an async reset drops them at once.
  assign bus.psel    = (state_q == StSetup) || (state_q == StAccess);
  assign bus.penable = (state_q == StAccess);
  assign bus.paddr   = paddr_q;
  assign bus.pdata   = pdata_q;
  assign bus.pstb    = pstb_q;
  assign bus.pwrite  = pwrite_q;

  assign bus.m0_ready = (state_q == StResp) && !grant_q;
  assign bus.m1_ready = (state_q == StResp) && grant_q;
  assign bus.m0_rdata = bus.m0_ready ? rdata_q : '0;
  assign bus.m1_rdata = bus.m1_ready ? rdata_q : '0;
  assign bus.m0_err   = bus.m0_ready & err_q;
  assign bus.m1_err   = bus.m1_ready & err_q;
endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter with a small word-addressed SRAM-style slave that answers
// one cycle into ACCESS, flags misaligned addresses, and can be stalled to exercise the watchdog.
module tb_apb_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  logic stall   = 1'b0;
  int   nvec    = 0;
  int   nerr    = 0;

  always #5 pclk = ~pclk;

  apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  // Slave model
  logic [DW-1:0] mem [64];
  logic [5:0]    widx;
  logic          misal;

  assign widx       = bus.paddr[7:2];
  assign misal      = bus.paddr[1:0] != 2'b00;
  assign bus.prdata = misal ? '0 : mem[widx];
  assign bus.perr   = bus.pready & misal;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) bus.pready <= 1'b0;
    else          bus.pready <= bus.psel && bus.penable && !bus.pready && !stall;
  end

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h11223344;
    end else if (bus.psel && bus.penable && bus.pready && bus.pwrite && !misal) begin
      for (int b = 0; b < int'(SW); b++)
        if (bus.pstb[b]) mem[widx][8*b +: 8] <= bus.pdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input bit m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic wr, input logic [SW-1:0] s, input logic rq);
    if (m) begin
      bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_write = wr; bus.m1_stb = s; bus.m1_req = rq;
    end else begin
      bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_write = wr; bus.m0_stb = s; bus.m0_req = rq;
    end
  endtask

  // Issues one request from the IDLE cycle, returns the response and the cycle of ready (-1: none).
  task automatic xfer(input bit m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic wr, input logic [SW-1:0] s,
                      output logic [DW-1:0] rd, output logic er, output int lat);
    drive(m, a, wd, wr, s, 1'b1);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (m ? bus.m1_ready : bus.m0_ready) begin
        lat = c;
        rd  = m ? bus.m1_rdata : bus.m0_rdata;
        er  = m ? bus.m1_err : bus.m0_err;
        break;
      end
    end
    drive(m, '0, '0, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    tick();
    tick();
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [3*DW+2*AW+SW+8-1:0] obs;
    presetn = 1'b0;
    tick();
    obs = {bus.paddr, bus.pdata, bus.pstb, bus.pwrite, bus.psel, bus.penable,
           bus.m0_ready, bus.m1_ready, bus.m0_err, bus.m1_err, 1'b0, bus.m0_rdata, bus.m1_rdata,
           AW'(0)};
    nvec++;
    if (obs !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got %h, want all zero", obs);
    end
    nvec++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      nerr++;
      $display("FAIL reset_psel_penable: got %b%b, want 00", bus.psel, bus.penable);
    end
    presetn = 1'b1;
    tick();
    nvec++;
    if (bus.psel !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle_no_req: psel %b, want 0", bus.psel);
    end
  endtask

  task automatic test_single_read();
    drive(1'b1, 32'h10, '0, 1'b0, 4'hF, 1'b1);
    tick();
    nvec++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b100 || bus.paddr !== 32'h10) begin
      nerr++;
      $display("FAIL read_setup: sel/en/wr %b%b%b addr %h, want 100 addr 10",
               bus.psel, bus.penable, bus.pwrite, bus.paddr);
    end
    tick();
    nvec++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      nerr++;
      $display("FAIL read_access: sel/en %b%b, want 11", bus.psel, bus.penable);
    end
    tick();
    nvec++;
    if (bus.m1_ready !== 1'b0) begin
      nerr++;
      $display("FAIL read_early_ready: m1_ready %b in cycle 3, want 0", bus.m1_ready);
    end
    tick();
    nvec++;
    if ({bus.m1_ready, bus.m1_err, bus.m0_ready} !== 3'b100 || bus.m1_rdata !== 32'hDEADBEEF
        || bus.m0_rdata !== '0 || bus.psel !== 1'b0) begin
      nerr++;
      $display("FAIL read_resp: rdy/err/m0rdy %b%b%b rdata %h m0_rdata %h psel %b, want 100 deadbeef 0 0",
               bus.m1_ready, bus.m1_err, bus.m0_ready, bus.m1_rdata, bus.m0_rdata, bus.psel);
    end
    drive(1'b1, '0, '0, 1'b0, '0, 1'b0);
    tick();
    nvec++;
    if (bus.m1_ready !== 1'b0 || bus.m1_rdata !== '0) begin
      nerr++;
      $display("FAIL read_pulse_width: m1_ready %b rdata %h in cycle 5, want 0 0",
               bus.m1_ready, bus.m1_rdata);
    end
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    xfer(1'b0, 32'h20, 32'h000000AA, 1'b1, 4'h1, rd, er, lat);
    nvec++;
    if (lat !== 4 || er !== 1'b0 || rd !== '0) begin
      nerr++;
      $display("FAIL byte_write: lat %0d err %b rdata %h, want 4 0 0", lat, er, rd);
    end
    xfer(1'b0, 32'h20, '0, 1'b0, 4'hF, rd, er, lat);
    nvec++;
    if (lat !== 4 || er !== 1'b0 || rd !== 32'h112233AA) begin
      nerr++;
      $display("FAIL byte_readback: lat %0d err %b rdata %h, want 4 0 112233aa", lat, er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int first  = -1;
    int second = -1;
    drive(1'b0, 32'h10, '0, 1'b0, 4'hF, 1'b1);
    for (int c = 1; c <= 30 && second < 0; c++) begin
      tick();
      if (bus.m0_ready) begin
        if (first < 0) first = c;
        else           second = c;
      end
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    nvec++;
    if (first !== 4 || second !== 9) begin
      nerr++;
      $display("FAIL back_to_back: ready cycles %0d,%0d, want 4,9", first, second);
    end
  endtask

  task automatic test_misaligned();
    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    xfer(1'b1, 32'h13, '0, 1'b0, 4'hF, rd, er, lat);
    nvec++;
    if (lat !== 4 || er !== 1'b1) begin
      nerr++;
      $display("FAIL misaligned: lat %0d err %b, want 4 1", lat, er);
    end
  endtask

  task automatic test_watchdog();
    int   acc = 0;
    int   lat = -1;
    logic [DW-1:0] rd = '1;
    logic er = 1'b0;
    logic sel = 1'b1;
    stall = 1'b1;
    drive(1'b1, 32'h10, '0, 1'b0, 4'hF, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.psel && bus.penable) acc++;
      if (bus.m1_ready) begin
        lat = c; rd = bus.m1_rdata; er = bus.m1_err; sel = bus.psel;
        break;
      end
    end
    drive(1'b1, '0, '0, 1'b0, '0, 1'b0);
    stall = 1'b0;
    tick();
    nvec++;
    if (acc !== 16 || lat !== 18) begin
      nerr++;
      $display("FAIL watchdog_timing: access cycles %0d ready cycle %0d, want 16 18", acc, lat);
    end
    nvec++;
    if (rd !== '0 || er !== 1'b1 || sel !== 1'b0) begin
      nerr++;
      $display("FAIL watchdog_resp: rdata %h err %b psel %b, want 0 1 0", rd, er, sel);
    end
  endtask

  task automatic test_contention();
    int g [4];
    int n = 0;
    int exp [4];
`ifdef APB_ARB_RR_EN
    exp = '{0, 1, 0, 1};
`else
    exp = '{0, 0, 0, 0};
`endif
    do_reset();
    drive(1'b0, 32'h10, '0, 1'b0, 4'hF, 1'b1);
    drive(1'b1, 32'h20, '0, 1'b0, 4'hF, 1'b1);
    for (int c = 1; c <= 40 && n < 4; c++) begin
      tick();
      if (bus.m0_ready)      begin g[n] = 0; n++; end
      else if (bus.m1_ready) begin g[n] = 1; n++; end
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    drive(1'b1, '0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    nvec++;
    if (n !== 4) begin
      nerr++;
      $display("FAIL contention_count: %0d grants, want 4", n);
    end
    for (int i = 0; i < n; i++) begin
      nvec++;
      if (g[i] !== exp[i]) begin
        nerr++;
        $display("FAIL contention_grant%0d: master %0d, want %0d", i, g[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int            pulses = 0;
    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    stall = 1'b1;
    drive(1'b0, 32'h10, '0, 1'b0, 4'hF, 1'b1);
    tick();
    tick();
    tick();
    nvec++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      nerr++;
      $display("FAIL mid_in_access: sel/en %b%b, want 11", bus.psel, bus.penable);
    end
    presetn = 1'b0;
    #1;
    nvec++;
    if ({bus.psel, bus.penable} !== 2'b00) begin
      nerr++;
      $display("FAIL mid_async_abort: sel/en %b%b, want 00", bus.psel, bus.penable);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    presetn = 1'b1;
    stall   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.m0_ready || bus.m1_ready || bus.psel) pulses++;
    end
    nvec++;
    if (pulses !== 0) begin
      nerr++;
      $display("FAIL mid_no_ready: %0d cycles with ready/psel after release, want 0", pulses);
    end
    xfer(1'b0, 32'h10, '0, 1'b0, 4'hF, rd, er, lat);
    nvec++;
    if (lat !== 4 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL mid_recover: lat %0d err %b rdata %h, want 4 0 deadbeef", lat, er, rd);
    end
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    drive(1'b1, '0, '0, 1'b0, '0, 1'b0);
    test_reset();
    test_single_read();
    test_byte_write();
    test_back_to_back();
    test_misaligned();
    test_watchdog();
    test_contention();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
